// File: rtl/fifo_sb_pkg.sv
// fifo_sb_pkg: shared state encoding, limits and helpers for fifo_scoreboard.
// Optional DUT flag checking is built only when FIFO_SB_FLAG_CHK_EN is defined.
package fifo_sb_pkg;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_RUN  = 2'd1,
    SB_HALT = 2'd2
  } sb_state_e;

  localparam int RD_LAT_MAX = 4;
  localparam int SAT_W      = 32;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(
    input logic [SAT_W-1:0] v,
    input int unsigned      w
  );
    logic [SAT_W-1:0] top;
    top = (w >= SAT_W) ? '1
        : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v >= top) ? top : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_sb_delay.sv
// fifo_sb_delay: token-valid + expected-data shift line of RD_LAT stages.
// RD_LAT=0 is a pure bypass; latencies above RD_LAT_MAX are clamped.
module fifo_sb_delay
  import fifo_sb_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data
);

  localparam int STAGES = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = &{1'b0, clk, rst, flush};
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_pipe
      logic [STAGES-1:0]    vld;
      logic [DATA_SIZE-1:0] dat [STAGES];

      // Shift tokens one stage per cycle; flush drops everything in flight.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld <= '0;
          for (int i = 0; i < STAGES; i++) begin
            dat[i] <= '0;
          end
        end else begin
          vld[0] <= in_valid & ~flush;
          dat[0] <= in_data;
          for (int i = 1; i < STAGES; i++) begin
            vld[i] <= vld[i-1] & ~flush;
            dat[i] <= dat[i-1];
          end
        end
      end

      assign out_valid = vld[STAGES-1];
      assign out_data  = dat[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/fifo_scoreboard.sv
// fifo_scoreboard: reference-queue checker for a single-clock FIFO DUT.
// Define FIFO_SB_FLAG_CHK_EN to also check DUT full/empty flags.
module fifo_scoreboard
  import fifo_sb_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4,
  parameter int RD_LAT    = 1,
  parameter int CNT_W     = 16,
  parameter int ERR_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [DATA_SIZE-1:0] rd_data,
  input  logic                 dut_full,
  input  logic                 dut_empty,
  output logic                 match_pulse,
  output logic                 mismatch_pulse,
  output logic [CNT_W-1:0]     chk_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 ovf_err,
  output logic                 unf_err,
  output logic                 flag_err,
  output logic                 fail_valid,
  output logic [DATA_SIZE-1:0] first_fail_exp,
  output logic [DATA_SIZE-1:0] first_fail_got,
  output logic [ADDR_SIZE:0]   sb_level,
  output logic [1:0]           sb_state
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam int LW    = ADDR_SIZE + 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  sb_state_e            state;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wptr;
  logic [ADDR_SIZE-1:0] rptr;

  logic                 active;
  logic                 push_req;
  logic                 pop_req;
  logic                 q_full;
  logic                 q_empty;
  logic                 do_push;
  logic                 do_pop;

  logic                 d_vld;
  logic [DATA_SIZE-1:0] d_exp;
  logic                 cmp_vld;
  logic                 cmp_eq;
  logic                 cmp_bad;
  logic                 hit_limit;
  logic [CNT_W-1:0]     chk_inc;
  logic [CNT_W-1:0]     err_inc;

  assign active   = (state != SB_HALT);
  assign push_req = wr_en & ~dut_full;
  assign pop_req  = rd_en & ~dut_empty;
  assign q_full   = (sb_level == LVL_FULL);
  assign q_empty  = (sb_level == '0);

  // A full queue refuses the write even alongside a pop: at full, wptr
  // equals rptr and the write would clobber the word being read out.
  assign do_push  = active & push_req & ~q_full;
  assign do_pop   = active & pop_req & ~q_empty;

  assign sb_state = state;

  // Reference storage; contents are only meaningful below sb_level.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping for accepted pushes and pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      sb_level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + ADDR_SIZE'(1);
      end
      if (do_pop) begin
        rptr <= rptr + ADDR_SIZE'(1);
      end
      sb_level <= sb_level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Sticky overflow/underflow; nothing new is recorded once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (active) begin
      if (push_req & q_full) begin
        ovf_err <= 1'b1;
      end
      if (pop_req & q_empty) begin
        unf_err <= 1'b1;
      end
    end
  end

  fifo_sb_delay #(
    .DATA_SIZE (DATA_SIZE),
    .RD_LAT    (RD_LAT)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .flush     (~active),
    .in_valid  (do_pop),
    .in_data   (mem[rptr]),
    .out_valid (d_vld),
    .out_data  (d_exp)
  );

  assign cmp_vld = d_vld & active;
  assign cmp_eq  = (d_exp == rd_data);
  assign cmp_bad = cmp_vld & ~cmp_eq;

  assign chk_inc = CNT_W'(sat_inc(SAT_W'(chk_cnt), CNT_W));
  assign err_inc = CNT_W'(sat_inc(SAT_W'(err_cnt), CNT_W));

  assign hit_limit = (ERR_LIMIT != 0) && cmp_bad
                  && (err_inc == CNT_W'(ERR_LIMIT));

  // Compare result pulses, counters and first-failure capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
      chk_cnt        <= '0;
      err_cnt        <= '0;
      fail_valid     <= 1'b0;
      first_fail_exp <= '0;
      first_fail_got <= '0;
    end else begin
      match_pulse    <= cmp_vld & cmp_eq;
      mismatch_pulse <= cmp_bad;
      if (cmp_vld) begin
        chk_cnt <= chk_inc;
      end
      if (cmp_bad) begin
        err_cnt <= err_inc;
        if (!fail_valid) begin
          fail_valid     <= 1'b1;
          first_fail_exp <= d_exp;
          first_fail_got <= rd_data;
        end
      end
    end
  end

  // Run control: start on the first accepted push, halt at the error limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SB_IDLE;
    end else begin
      unique case (state)
        SB_IDLE: if (do_push)   state <= SB_RUN;
        SB_RUN:  if (hit_limit) state <= SB_HALT;
        SB_HALT: state <= SB_HALT;
        default: state <= SB_IDLE;
      endcase
    end
  end

`ifdef FIFO_SB_FLAG_CHK_EN
  // DUT flags must agree with the occupancy held at the start of the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_err <= 1'b0;
    end else if (state == SB_RUN) begin
      if ((dut_empty != q_empty) || (dut_full != q_full)) begin
        flag_err <= 1'b1;
      end
    end
  end
`else
  assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_scoreboard.sv
// tb_fifo_scoreboard: directed + random checks of fifo_scoreboard
// against a queue-based reference model.
module tb_fifo_scoreboard;

  localparam int DW      = 8;
  localparam int AW      = 4;
  localparam int DEPTH   = 16;
  localparam int LAT     = 1;
  localparam int CW      = 16;
  localparam int ERR_LIM = 8;
  localparam int CMAX    = (1 << CW) - 1;

`ifdef FIFO_SB_FLAG_CHK_EN
  localparam bit FLAG_ON = 1'b1;
`else
  localparam bit FLAG_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          dut_full = 1'b0;
  logic          dut_empty = 1'b0;
  logic          match_pulse;
  logic          mismatch_pulse;
  logic [CW-1:0] chk_cnt;
  logic [CW-1:0] err_cnt;
  logic          ovf_err;
  logic          unf_err;
  logic          flag_err;
  logic          fail_valid;
  logic [DW-1:0] first_fail_exp;
  logic [DW-1:0] first_fail_got;
  logic [AW:0]   sb_level;
  logic [1:0]    sb_state;

  fifo_scoreboard #(
    .DATA_SIZE (DW),
    .ADDR_SIZE (AW),
    .RD_LAT    (LAT),
    .CNT_W     (CW),
    .ERR_LIMIT (ERR_LIM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .dut_full       (dut_full),
    .dut_empty      (dut_empty),
    .match_pulse    (match_pulse),
    .mismatch_pulse (mismatch_pulse),
    .chk_cnt        (chk_cnt),
    .err_cnt        (err_cnt),
    .ovf_err        (ovf_err),
    .unf_err        (unf_err),
    .flag_err       (flag_err),
    .fail_valid     (fail_valid),
    .first_fail_exp (first_fail_exp),
    .first_fail_got (first_fail_got),
    .sb_level       (sb_level),
    .sb_state       (sb_state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int n_match_seen = 0;
  int n_mism_seen  = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [DW-1:0] d;
  } tok_t;

  logic [DW-1:0] mq[$];
  tok_t          pend[$];
  int            m_cyc = 0;
  int            m_chk = 0;
  int            m_err = 0;
  int            m_state = 0;
  bit            m_match = 0;
  bit            m_mism = 0;
  bit            m_ovf = 0;
  bit            m_unf = 0;
  bit            m_flag = 0;
  bit            m_fv = 0;
  logic [DW-1:0] m_fexp = '0;
  logic [DW-1:0] m_fgot = '0;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic m_reset();
    mq.delete();
    pend.delete();
    m_chk = 0; m_err = 0; m_state = 0;
    m_match = 0; m_mism = 0;
    m_ovf = 0; m_unf = 0; m_flag = 0;
    m_fv = 0; m_fexp = '0; m_fgot = '0;
  endtask

  task automatic m_step();
    int lvl;
    bit pushed;
    bit bad;
    lvl = mq.size();
    m_match = 0;
    m_mism = 0;
    pushed = 0;
    bad = 0;
    if (m_state != 2) begin
      if (rd_en && !dut_empty) begin
        if (lvl == 0) m_unf = 1;
        else begin
          tok_t t;
          t.due = m_cyc + LAT;
          t.d = mq.pop_front();
          pend.push_back(t);
        end
      end
      if (wr_en && !dut_full) begin
        if (lvl == DEPTH) m_ovf = 1;
        else begin
          mq.push_back(wr_data);
          pushed = 1;
        end
      end
      if (FLAG_ON && m_state == 1 &&
          ((dut_empty != (lvl == 0)) || (dut_full != (lvl == DEPTH))))
        m_flag = 1;
      while (pend.size() > 0 && pend[0].due == m_cyc) begin
        tok_t t = pend.pop_front();
        m_chk = sat(m_chk);
        if (t.d == rd_data) m_match = 1;
        else begin
          m_mism = 1;
          bad = 1;
          m_err = sat(m_err);
          if (!m_fv) begin
            m_fv = 1; m_fexp = t.d; m_fgot = rd_data;
          end
        end
      end
      if (m_state == 0 && pushed) m_state = 1;
      else if (m_state == 1 && bad && ERR_LIM != 0 && m_err == ERR_LIM) begin
        m_state = 2;
        pend.delete();
      end
    end
    m_cyc++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step();
  end

  function automatic logic [DW-1:0] next_exp();
    if (pend.size() > 0 && pend[0].due == m_cyc) return pend[0].d;
    return '0;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("match_pulse", 32'(match_pulse), 32'(m_match));
    chk("mismatch_pulse", 32'(mismatch_pulse), 32'(m_mism));
    chk("chk_cnt", 32'(chk_cnt), 32'(m_chk));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("unf_err", 32'(unf_err), 32'(m_unf));
    chk("flag_err", 32'(flag_err), 32'(m_flag));
    chk("fail_valid", 32'(fail_valid), 32'(m_fv));
    chk("first_fail_exp", 32'(first_fail_exp), 32'(m_fexp));
    chk("first_fail_got", 32'(first_fail_got), 32'(m_fgot));
    chk("sb_level", 32'(sb_level), 32'(mq.size()));
    chk("sb_state", 32'(sb_state), 32'(m_state));
    if (match_pulse) n_match_seen++;
    if (mismatch_pulse) n_mism_seen++;
  end

  // ---------------- stimulus ----------------
  bit            auto_rd = 1'b1;
  logic [DW-1:0] xmask = '0;

  task automatic tick();
    if (auto_rd) rd_data = next_exp() ^ xmask;
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit we, input logic [DW-1:0] wd,
                       input bit re);
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    tick();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_match"}, 32'(match_pulse), 0);
    chk({tag, "_mism"}, 32'(mismatch_pulse), 0);
    chk({tag, "_chk"}, 32'(chk_cnt), 0);
    chk({tag, "_err"}, 32'(err_cnt), 0);
    chk({tag, "_ovf"}, 32'(ovf_err), 0);
    chk({tag, "_unf"}, 32'(unf_err), 0);
    chk({tag, "_flag"}, 32'(flag_err), 0);
    chk({tag, "_fv"}, 32'(fail_valid), 0);
    chk({tag, "_fexp"}, 32'(first_fail_exp), 0);
    chk({tag, "_fgot"}, 32'(first_fail_got), 0);
    chk({tag, "_level"}, 32'(sb_level), 0);
    chk({tag, "_state"}, 32'(sb_state), 0);
  endtask

  function automatic logic [DW-1:0] vpat(input int i);
    return DW'(i * 7 + 1);
  endfunction

  initial begin
    int m0;
    int e0;
    repeat (2) @(negedge clk);
    #1;
    all_zero("reset");
    rst = 1'b0;

    // three matching reads
    drive(1, 8'h11, 0);
    drive(1, 8'h22, 0);
    drive(1, 8'h33, 0);
    chk("t1_level3", 32'(sb_level), 3);
    chk("t1_run", 32'(sb_state), 1);
    m0 = n_match_seen;
    drive(0, '0, 1);
    drive(0, '0, 1);
    drive(0, '0, 1);
    drive(0, '0, 0);
    drive(0, '0, 0);
    chk("t1_matches", 32'(n_match_seen - m0), 3);
    chk("t1_chk", 32'(chk_cnt), 3);
    chk("t1_err", 32'(err_cnt), 0);
    chk("t1_level0", 32'(sb_level), 0);

    // first-failure capture
    drive(1, 8'hA5, 0);
    xmask = 8'hFF;
    drive(0, '0, 1);
    drive(0, '0, 0);
    chk("t2_mism_pulse", 32'(mismatch_pulse), 1);
    chk("t2_err", 32'(err_cnt), 1);
    chk("t2_fexp", 32'(first_fail_exp), 32'h A5);
    chk("t2_fgot", 32'(first_fail_got), 32'h 5A);
    chk("t2_fv", 32'(fail_valid), 1);
    xmask = 8'h00;
    drive(1, 8'h3C, 0);
    xmask = 8'h0F;
    drive(0, '0, 1);
    drive(0, '0, 0);
    xmask = 8'h00;
    chk("t2_err2", 32'(err_cnt), 2);
    chk("t2_fexp_hold", 32'(first_fail_exp), 32'h A5);
    chk("t2_fgot_hold", 32'(first_fail_got), 32'h 5A);
    chk("t2_chk", 32'(chk_cnt), 5);

    // overflow: 20 pushes into a 16-deep queue
    rst = 1'b1;
    drive(0, '0, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1, vpat(i), 0);
      if (i == 15) begin
        chk("t3_level16", 32'(sb_level), 16);
        chk("t3_ovf_before", 32'(ovf_err), 0);
      end
      if (i == 16) chk("t3_ovf_at17", 32'(ovf_err), 1);
    end
    chk("t3_level_hold", 32'(sb_level), 16);
    auto_rd = 1'b0;
    wr_en = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      rd_en = (j < 16);
      rd_data = (j > 0) ? vpat(j - 1) : '0;
      tick();
    end
    rd_en = 1'b0;
    auto_rd = 1'b1;
    drive(0, '0, 0);
    chk("t3_chk16", 32'(chk_cnt), 16);
    chk("t3_err0", 32'(err_cnt), 0);
    chk("t3_drained", 32'(sb_level), 0);

    // underflow
    m0 = n_match_seen;
    e0 = n_mism_seen;
    drive(0, '0, 1);
    drive(0, '0, 0);
    drive(0, '0, 0);
    chk("t4_unf", 32'(unf_err), 1);
    chk("t4_chk", 32'(chk_cnt), 16);
    chk("t4_no_pulse", 32'((n_match_seen - m0) + (n_mism_seen - e0)), 0);

    // error limit halt, then reset mid-stream
    for (int i = 0; i < 10; i++) drive(1, DW'(8'h40 + i), 0);
    xmask = 8'hFF;
    for (int i = 0; i < 10; i++) drive(0, '0, 1);
    drive(0, '0, 0);
    drive(0, '0, 0);
    chk("t5_halt", 32'(sb_state), 2);
    chk("t5_err", 32'(err_cnt), 8);
    chk("t5_chk", 32'(chk_cnt), 24);
    chk("t5_level", 32'(sb_level), 1);
    m0 = n_match_seen;
    e0 = n_mism_seen;
    for (int i = 0; i < 4; i++) drive(1, DW'(i), 1);
    chk("t5_frozen_chk", 32'(chk_cnt), 24);
    chk("t5_frozen_err", 32'(err_cnt), 8);
    chk("t5_frozen_level", 32'(sb_level), 1);
    chk("t5_no_pulse", 32'((n_match_seen - m0) + (n_mism_seen - e0)), 0);
    chk("t5_unf_hold", 32'(unf_err), 1);
    rst = 1'b1;
    #2;
    all_zero("midrst");
    xmask = 8'h00;
    drive(0, '0, 0);
    rst = 1'b0;

    // flag consistency
    dut_empty = 1'b1;
    drive(1, 8'h77, 0);
    chk("t6_flag_pre", 32'(flag_err), 0);
    drive(0, '0, 0);
    chk("t6_flag", 32'(flag_err), 32'(FLAG_ON));
    dut_empty = 1'b0;
    rst = 1'b1;
    drive(0, '0, 0);
    rst = 1'b0;

    // randomized traffic with occasional corruption and one reset
    for (int c = 0; c < 700; c++) begin
      if (c == 350) rst = 1'b1;
      if (c == 352) rst = 1'b0;
      dut_full  = ($urandom_range(0, 99) < 5);
      dut_empty = ($urandom_range(0, 99) < 5);
      xmask = ($urandom_range(0, 59) == 0) ? DW'($urandom_range(1, 255)) : '0;
      drive(($urandom_range(0, 99) < 55), DW'($urandom),
            ($urandom_range(0, 99) < 45));
    end
    rst = 1'b1;
    drive(0, '0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/fifo_scoreboard.md
Name: fifo_scoreboard

Overview:
- Synthesizable, parametrised self-checking scoreboard for a single-clock FIFO DUT.
- Mirrors every accepted write into an internal reference queue and compares every accepted read against the queued expected data after a configurable read latency.
- Reports matches, mismatches, flag inconsistencies and queue overflow/underflow.
- Sits beside a FIFO instance on the read/write port side, for GLS benches and on-chip BIST.

Parameters:
- DATA_SIZE, 8, data width in bits.
- ADDR_SIZE, 4, reference queue address width; DEPTH = 2**ADDR_SIZE entries.
- RD_LAT, 1, cycles from accepted rd_en edge to DUT rd_data valid; legal range 0..4.
- CNT_W, 16, width of the check and error counters.
- ERR_LIMIT, 8, error count at which checking halts; 0 means never halt.

Ports:
- clk  in  1  single clock for the DUT ports and the scoreboard.
- rst  in  1  asynchronous, active-high reset; clears all state.
- wr_en  in  1  DUT write enable.
- wr_data  in  DATA_SIZE  DUT write data.
- rd_en  in  1  DUT read enable.
- rd_data  in  DATA_SIZE  DUT read data.
- dut_full  in  1  DUT full flag.
- dut_empty  in  1  DUT empty flag.
- match_pulse  out  1  one-cycle pulse on a matched compare.
- mismatch_pulse  out  1  one-cycle pulse on a failed compare.
- chk_cnt  out  CNT_W  total compares performed; saturating.
- err_cnt  out  CNT_W  total mismatches; saturating.
- ovf_err  out  1  sticky: push attempted with reference queue full.
- unf_err  out  1  sticky: pop attempted with reference queue empty.
- flag_err  out  1  sticky: DUT flag disagrees with reference level.
- fail_valid  out  1  sticky: first-failure capture holds data.
- first_fail_exp  out  DATA_SIZE  expected data of the first mismatch.
- first_fail_got  out  DATA_SIZE  received data of the first mismatch.
- sb_level  out  ADDR_SIZE+1  current reference queue occupancy, 0..DEPTH.
- sb_state  out  2  FSM state.

Behaviour:
- Reset values: all outputs 0; queue pointers 0; latency pipe flushed; FSM state IDLE.
- Reset asserted mid-operation discards all in-flight compares immediately.
- Push condition: wr_en & !dut_full.
  - Writes wr_data at wptr; wptr wraps modulo DEPTH.
  - If sb_level==DEPTH, no write occurs and ovf_err is set.
- Pop condition: rd_en & !dut_empty.
  - Reads the expected value at rptr and launches a compare token.
  - If sb_level==0, no token is launched and unf_err is set.
- Simultaneous push and pop: sb_level unchanged, both pointers advance. At level 0, the pop is the underflow case and the push still occurs.
- Compare timing:
  - A token launched at edge N is compared with rd_data sampled at edge N+RD_LAT.
  - RD_LAT=0: rd_data is sampled at edge N, i.e. first-word-fall-through.
  - match_pulse or mismatch_pulse is registered and high for the one cycle following the compare edge.
  - chk_cnt increments on every compare; err_cnt increments on every mismatch.
  - Both counters saturate at all-ones.
- First failure capture:
  - On the first mismatch after reset, latch expected and received data and set fail_valid.
  - Later mismatches do not overwrite the capture.
- FSM, encoded IDLE=0, RUN=1, HALT=2:
  - IDLE -> RUN on the first push.
  - RUN -> HALT when ERR_LIMIT!=0 and err_cnt reaches ERR_LIMIT.
  - HALT: pushes, pops, compares and counters are frozen; sticky flags hold. Exit only by rst.
  - Tokens in flight on entry to HALT are dropped.
- Sticky flags clear only on rst.

Optional Feature:
- Macro: FIFO_SB_FLAG_CHK_EN.
- Defined:
  - Each cycle in RUN, set flag_err if dut_empty != (sb_level==0), or dut_full != (sb_level==DEPTH).
  - The comparison uses sb_level as registered at the start of the cycle.
- Undefined:
  - flag_err is tied to 0 and no flag-compare logic is synthesized.

Decomposition:
- Package fifo_sb_pkg holds:
  - the state enum/localparams SB_IDLE, SB_RUN, SB_HALT;
  - RD_LAT_MAX=4;
  - the saturating-increment function.
- One sub-module, fifo_sb_delay: parametrised valid+data shift line of RD_LAT stages, with a bypass for RD_LAT=0. It carries the expected data alongside its token-valid bit.

Test Plan:
- Write 0x11,0x22,0x33, then read 3 with matching DUT data at RD_LAT=1 -> 3 match_pulse, chk_cnt=3, err_cnt=0, sb_level back to 0.
- Write 0xA5, DUT returns 0x5A -> mismatch_pulse, err_cnt=1, first_fail_exp=0xA5, first_fail_got=0x5A, fail_valid=1; a second bad read leaves the capture unchanged.
- 20 pushes with dut_full held 0 and no pops (DEPTH=16) -> sb_level=16, ovf_err=1 on push 17; the queue still holds the first 16 values.
- Pop with dut_empty=0 while sb_level=0 -> unf_err=1, no compare pulse, chk_cnt unchanged.
- ERR_LIMIT=2, two mismatches -> sb_state=HALT; further reads produce no pulses and counters frozen; assert rst mid-stream -> all outputs 0, state IDLE.
- With FIFO_SB_FLAG_CHK_EN, hold dut_empty=1 after one push -> flag_err=1 the next cycle; without the macro, flag_err stays 0.
